net_bit_collector: RTL and testbench

//  Stage directly downstream of the netlist connection parser. Consumes one pin-to-net

---
 rtl/netcoll_pkg.sv | 25 ++
 rtl/netcoll_cam.sv | 73 +++++++
 rtl/net_bit_collector.sv | 151 +++++++++++++++
 tb/tb_net_bit_collector.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/netcoll_pkg.sv
// Shared types and constants for the net bit collector.
package netcoll_pkg;

    localparam int NET_W_DEF = 16;
    localparam int BIT_W_DEF = 4;
    localparam int DEPTH_DEF = 16;
    localparam int CNT_W_DEF = 8;

    // A net bit at the default widths: net id plus bit index within the bus.
    typedef struct packed {
        logic [NET_W_DEF-1:0] net;
        logic [BIT_W_DEF-1:0] bit_idx;
    } net_key_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    // Largest value a saturating counter of the given width can hold.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/netcoll_cam.sv
// Content-addressed table of distinct net bits with saturating reference counts.
// One parallel lookup port, one allocate port, one increment port and a clear-all.
module netcoll_cam
    import netcoll_pkg::*;
#(
    parameter int KEY_W = NET_W_DEF + BIT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] lookup_key,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx,
    input  logic             alloc_en,
    input  logic [IDX_W-1:0] alloc_idx,
    input  logic [KEY_W-1:0] alloc_key,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic             clr_all,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [KEY_W-1:0] rd_key,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [KEY_W-1:0] key_q   [DEPTH];
    logic [CNT_W-1:0] cnt_q   [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Parallel compare of the lookup key against every valid entry.
    always_comb begin
        // NOTE: defaults before the loop keep every path assigned, so no latch is inferred.
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && key_q[i] == lookup_key) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Valid bits: set on allocate, all dropped at end of drain.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clr_all) begin
            valid_q <= '0;
        end else if (alloc_en) begin
            valid_q[alloc_idx] <= 1'b1;
        end
    end

    // Key and count storage: written on allocate, count bumped (saturating) on a hit.
    // NOTE: the storage array is not reset; an entry's contents mean nothing until its valid bit is set.
    always_ff @(posedge clk) begin
        if (alloc_en) begin
            key_q[alloc_idx] <= alloc_key;
            cnt_q[alloc_idx] <= CNT_W'(1);
        end
        if (inc_en && cnt_q[inc_idx] != CNT_MAX) begin
            cnt_q[inc_idx] <= cnt_q[inc_idx] + CNT_W'(1);
        end
    end

    assign rd_key = key_q[rd_idx];
    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/net_bit_collector.sv
// Merges repeated net-bit references within a module and drains the unique
// list, with reference counts, in first-seen order once the module ends.
module net_bit_collector
    import netcoll_pkg::*;
#(
    parameter int NET_W = NET_W_DEF,
    parameter int BIT_W = BIT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NET_W-1:0] in_net,
    input  logic [BIT_W-1:0] in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NET_W-1:0] out_net,
    output logic [BIT_W-1:0] out_bit,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_last,
    output logic             out_ovf,
    output logic             busy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int N_W   = $clog2(DEPTH + 1);
    localparam int KEY_W = NET_W + BIT_W;

    state_t           state_q, state_d;
    logic [N_W-1:0]   n_used_q, n_used_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             alloc_en;
    logic             inc_en;
    logic             clr_all;
    logic [KEY_W-1:0] rd_key;
    logic [CNT_W-1:0] rd_cnt;

    logic             accept_in;
    logic             accept_out;
    logic             full;
    logic             last_entry;

    assign accept_in  = in_valid && in_ready;
    assign accept_out = out_valid && out_ready;
    assign full       = (n_used_q == N_W'(DEPTH));
    assign last_entry = (N_W'(rd_ptr_q) == n_used_q - N_W'(1));

    netcoll_cam #(
        .KEY_W (KEY_W),
        .CNT_W (CNT_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_cam (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_key ({in_net, in_bit}),
        .hit        (hit),
        .hit_idx    (hit_idx),
        .alloc_en   (alloc_en),
        .alloc_idx  (IDX_W'(n_used_q)),
        .alloc_key  ({in_net, in_bit}),
        .inc_en     (inc_en),
        .inc_idx    (hit_idx),
        .clr_all    (clr_all),
        .rd_idx     (rd_ptr_q),
        .rd_key     (rd_key),
        .rd_cnt     (rd_cnt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: the last input record starts a drain, the last output beat ends it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: if (accept_in && in_last)     state_d = DRAIN;
            DRAIN:   if (accept_out && last_entry) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // FSM outputs: handshake and entry fields, zero whenever nothing is being emitted.
    always_comb begin
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == DRAIN);
        busy      = (state_q == DRAIN);
        out_last  = out_valid && last_entry;
        out_ovf   = out_last && ovf_q;
        out_net   = out_valid ? rd_key[KEY_W-1:BIT_W] : '0;
        out_bit   = out_valid ? rd_key[BIT_W-1:0]     : '0;
        out_cnt   = out_valid ? rd_cnt                : '0;
    end

    // Table bookkeeping: hit/allocate/drop on input, pointer walk and clear on output.
    always_comb begin
        n_used_d = n_used_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        alloc_en = 1'b0;
        inc_en   = 1'b0;
        clr_all  = 1'b0;
        if (accept_in) begin
            if (hit) begin
                inc_en = 1'b1;
            end else if (!full) begin
                alloc_en = 1'b1;
                n_used_d = n_used_q + N_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (accept_out) begin
            if (last_entry) begin
                clr_all  = 1'b1;
                n_used_d = '0;
                rd_ptr_d = '0;
                ovf_d    = 1'b0;
            end else begin
                rd_ptr_d = rd_ptr_q + IDX_W'(1);
            end
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_used_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            n_used_q <= n_used_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_net_bit_collector.sv
// Self-checking bench for net_bit_collector: directed tables, hand-written
// corner sequences and randomized modules against a queue-based reference model.
module tb_net_bit_collector;
    import netcoll_pkg::*;

    localparam int NET_W   = 16;
    localparam int BIT_W   = 4;
    localparam int DEPTH   = 16;
    localparam int CNT_W   = 8;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [NET_W-1:0] in_net;
    logic [BIT_W-1:0] in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [NET_W-1:0] out_net;
    logic [BIT_W-1:0] out_bit;
    logic [CNT_W-1:0] out_cnt;
    logic             out_last;
    logic             out_ovf;
    logic             busy;

    net_bit_collector #(
        .NET_W (NET_W),
        .BIT_W (BIT_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_net    (in_net),
        .in_bit    (in_bit),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_net   (out_net),
        .out_bit   (out_bit),
        .out_cnt   (out_cnt),
        .out_last  (out_last),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: unique keys in first-seen order with saturating counts.
    net_key_t exp_key[$];
    int       exp_cnt[$];
    bit       model_ovf;

    function automatic void model_clear();
        exp_key.delete();
        exp_cnt.delete();
        model_ovf = 1'b0;
    endfunction

    function automatic void model_add(input int net, input int b);
        net_key_t k;
        k.net     = 16'(net);
        k.bit_idx = 4'(b);
        foreach (exp_key[i]) begin
            if (exp_key[i] == k) begin
                if (exp_cnt[i] < CNT_TOP) exp_cnt[i]++;
                return;
            end
        end
        if (exp_key.size() < DEPTH) begin
            exp_key.push_back(k);
            exp_cnt.push_back(1);
        end else begin
            model_ovf = 1'b1;
        end
    endfunction

    // Captured output beats.
    int got_net[$];
    int got_bit[$];
    int got_cnt[$];
    int got_last[$];
    int got_ovf[$];

    // Present one record and hold it until accepted; starts and ends just after a rising edge.
    task automatic send(input int net, input int b, input bit last);
        int w = 0;
        in_valid = 1'b1;
        in_net   = 16'(net);
        in_bit   = 4'(b);
        in_last  = last;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_add(net, b);
    endtask

    // Collect one module's output beats, with out_ready low bp_pct percent of cycles.
    task automatic drain(input int bp_pct);
        bit done = 1'b0;
        int cyc  = 0;
        got_net.delete(); got_bit.delete(); got_cnt.delete();
        got_last.delete(); got_ovf.delete();
        while (!done && cyc < 400) begin
            out_ready = ($urandom_range(99) >= bp_pct);
            @(negedge clk);
            if (out_valid) begin
                check("in_ready_in_drain", in_ready, 0);
                check("busy_in_drain", busy, 1);
                if (out_ready) begin
                    got_net.push_back(out_net);
                    got_bit.push_back(out_bit);
                    got_cnt.push_back(out_cnt);
                    got_last.push_back(out_last);
                    got_ovf.push_back(out_ovf);
                    if (out_last) done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        out_ready = 1'b0;
        if (!done) check("drain_timeout", 0, 1);
    endtask

    // Compare the captured beats with the reference model, then start a fresh module.
    task automatic compare_module(input string tag);
        check({tag, "_count"}, got_net.size(), exp_key.size());
        for (int i = 0; i < got_net.size() && i < exp_key.size(); i++) begin
            bit l = (i == exp_key.size() - 1);
            check({tag, "_net"},  got_net[i],  exp_key[i].net);
            check({tag, "_bit"},  got_bit[i],  exp_key[i].bit_idx);
            check({tag, "_cnt"},  got_cnt[i],  exp_cnt[i]);
            check({tag, "_last"}, got_last[i], l);
            check({tag, "_ovf"},  got_ovf[i],  l ? model_ovf : 1'b0);
        end
        model_clear();
    endtask

    typedef struct {
        int net;
        int b;
        bit last;
    } rec_t;

    typedef struct {
        int net;
        int b;
        int cnt;
        bit last;
        bit ovf;
    } exp_t;

    rec_t recs1[3];
    exp_t exp1[2];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_net    = '0;
        in_bit    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();

        recs1[0] = '{net: 5, b: 0, last: 1'b0};
        recs1[1] = '{net: 7, b: 3, last: 1'b0};
        recs1[2] = '{net: 7, b: 3, last: 1'b1};
        exp1[0]  = '{net: 5, b: 0, cnt: 1, last: 1'b0, ovf: 1'b0};
        exp1[1]  = '{net: 7, b: 3, cnt: 2, last: 1'b1, ovf: 1'b0};

        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_out_net", out_net, 0);
        check("rst_out_cnt", out_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: table-driven basic merge, plus first-output latency.
        for (int i = 0; i < 3; i++) send(recs1[i].net, recs1[i].b, recs1[i].last);
        @(negedge clk);
        check("t1_first_out_latency", out_valid, 1);
        @(posedge clk);
        #1;
        drain(0);
        check("t1_count", got_net.size(), 2);
        for (int i = 0; i < 2 && i < got_net.size(); i++) begin
            check("t1_net",  got_net[i],  exp1[i].net);
            check("t1_bit",  got_bit[i],  exp1[i].b);
            check("t1_cnt",  got_cnt[i],  exp1[i].cnt);
            check("t1_last", got_last[i], exp1[i].last);
            check("t1_ovf",  got_ovf[i],  exp1[i].ovf);
        end
        model_clear();

        // Test 2: backpressure on entry 1 holds its fields stable.
        for (int i = 0; i < 3; i++) send(recs1[i].net, recs1[i].b, recs1[i].last);
        @(negedge clk);
        check("t2_e0_net", out_net, 5);
        check("t2_e0_last", out_last, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_net", out_net, 7);
            check("t2_hold_bit", out_bit, 3);
            check("t2_hold_cnt", out_cnt, 2);
            check("t2_hold_last", out_last, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t2_after_valid", out_valid, 0);
        check("t2_after_in_ready", in_ready, 1);
        check("t2_after_busy", busy, 0);
        @(posedge clk);
        #1;
        model_clear();

        // Test 3: overflow with 18 distinct keys, then a clean module.
        for (int i = 0; i < 18; i++) send(100 + i, i % 16, i == 17);
        drain(0);
        check("t3_ovf_expected", model_ovf, 1);
        compare_module("t3");
        send(1, 1, 1'b0);
        send(2, 2, 1'b1);
        drain(0);
        compare_module("t3_next");

        // Test 4: count saturation.
        for (int i = 0; i < 300; i++) send(3, 2, i == 299);
        drain(0);
        check("t4_single_cnt", (got_cnt.size() == 1) ? got_cnt[0] : -1, CNT_TOP);
        compare_module("t4");

        // Test 5: reset in the middle of a drain discards the rest.
        send(20, 1, 1'b0);
        send(21, 2, 1'b0);
        send(22, 3, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_in_ready", in_ready, 1);
        check("t5_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
        send(9, 1, 1'b0);
        send(9, 1, 1'b0);
        send(2, 0, 1'b1);
        drain(0);
        compare_module("t5");

        // Test 6: a record offered during DRAIN waits and lands in the next module.
        send(30, 0, 1'b0);
        send(31, 1, 1'b1);
        in_valid = 1'b1;
        in_net   = 16'd11;
        in_bit   = 4'd5;
        in_last  = 1'b0;
        drain(20);
        compare_module("t6");
        @(negedge clk);
        check("t6_held_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        model_add(11, 5);
        send(11, 5, 1'b1);
        drain(0);
        compare_module("t6_next");

        // Randomized modules: small key space to force hits and occasional overflow.
        for (int m = 0; m < 12; m++) begin
            int n = $urandom_range(1, 24);
            for (int r = 0; r < n; r++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send($urandom_range(0, 4), $urandom_range(0, 3), r == n - 1);
            end
            drain(30);
            compare_module("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
